// File: rtl/gpu_framebuffer.sv
// Parametrised dual-port framebuffer with a built-in frame fill engine.
// Port 1 is a read-only scan-out port, port 2 a read/write drawing port.
// The fill engine clears the frame at one pixel per clock and owns port 2
// while it runs.
module gpu_framebuffer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 200,
  parameter int BPP    = 1,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter logic [BPP-1:0] INIT_VALUE = {BPP{1'b1}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  input  logic           re1,
  output logic [BPP-1:0] rd_data1,
  output logic           rd_valid1,
  input  logic [X_W-1:0] x2,
  input  logic [Y_W-1:0] y2,
  input  logic           re2,
  input  logic           we2,
  input  logic [BPP-1:0] wr_data2,
  output logic [BPP-1:0] rd_data2,
  output logic           rd_valid2,
  input  logic           fill_start,
  input  logic [BPP-1:0] fill_color,
  output logic           busy,
  output logic           fill_done
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, FILL} fillState_e;

  fillState_e     state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [BPP-1:0] color_q, color_d;
  logic           done_q, done_d;

  logic [BPP-1:0] rdData1_q, rdData2_q;
  logic           rdValid1_q, rdValid2_q;

  logic           inRange1, inRange2;
  logic [AW-1:0]  addr1, addr2;
  logic           fillWe, drawWe, drawRe;

  // Pixel store; INIT_VALUE is the configuration-time content only.
  logic [BPP-1:0] mem [DEPTH] = '{default: INIT_VALUE};

  // Linear addresses at full width; range is checked on the raw coordinates
  // so an out-of-range x can never alias onto the next line.
  assign inRange1 = (int'(x1) < WIDTH) && (int'(y1) < HEIGHT);
  assign inRange2 = (int'(x2) < WIDTH) && (int'(y2) < HEIGHT);
  assign addr1    = AW'(int'(y1) * WIDTH + int'(x1));
  assign addr2    = AW'(int'(y2) * WIDTH + int'(x2));

  assign busy   = (state_q == FILL);
  assign fillWe = busy && !rst;
  assign drawRe = re2 && !busy;
  assign drawWe = we2 && inRange2 && !busy && !rst;

  // Fill engine state, counter and latched colour; reset aborts any fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

  // Fill engine next state: accept a start only when idle, stop after the last pixel.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d = FILL;
          cnt_d   = '0;
          color_d = fill_color;
        end
      end
      FILL: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory writes; the fill engine and the drawing port never write together.
  always_ff @(posedge clk) begin
    if (fillWe) begin
      mem[cnt_q] <= color_q;
    end else if (drawWe) begin
      mem[addr2] <= wr_data2;
    end
  end

  // Registered read ports; non-blocking reads return pre-write (old) content.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdData1_q  <= '0;
      rdValid1_q <= 1'b0;
      rdData2_q  <= '0;
      rdValid2_q <= 1'b0;
    end else begin
      rdValid1_q <= re1;
      rdData1_q  <= (re1 && inRange1) ? mem[addr1] : '0;
      rdValid2_q <= drawRe;
      rdData2_q  <= (drawRe && inRange2) ? mem[addr2] : '0;
    end
  end

  assign rd_data1  = rdData1_q;
  assign rd_valid1 = rdValid1_q;
  assign rd_data2  = rdData2_q;
  assign rd_valid2 = rdValid2_q;
  assign fill_done = done_q;

endmodule

// File: doc/gpu_framebuffer.md
Name: gpu_framebuffer

Overview:
Parametrised dual-port framebuffer for the graphics pipeline, generalising the 1-bit fixed-size pixel store to BPP-bit pixels and arbitrary WIDTH x HEIGHT. Port 1 is a read-only display/scan-out port. Port 2 is a read/write drawing port. A built-in fill engine clears the whole frame to a colour at one pixel per clock, and takes ownership of port 2 while running. Memory is an inferred synchronous array; the block uses no vendor primitives.

Parameters:
WIDTH, 320, pixels per line
HEIGHT, 200, lines per frame
BPP, 1, bits per pixel
X_W, 9, x coordinate width; must satisfy 2^X_W >= WIDTH
Y_W, 8, y coordinate width; must satisfy 2^Y_W >= HEIGHT
INIT_VALUE, all ones, power-up content of every pixel (BPP bits); not restored by reset

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous active-high reset
x1  in  X_W  port 1 x coordinate
y1  in  Y_W  port 1 y coordinate
re1  in  1  port 1 read request
rd_data1  out  BPP  port 1 read data
rd_valid1  out  1  port 1 read data valid
x2  in  X_W  port 2 x coordinate
y2  in  Y_W  port 2 y coordinate
re2  in  1  port 2 read request
we2  in  1  port 2 write request
wr_data2  in  BPP  port 2 write data
rd_data2  out  BPP  port 2 read data
rd_valid2  out  1  port 2 read data valid
fill_start  in  1  single-cycle request to fill the frame
fill_color  in  BPP  fill colour, sampled on an accepted fill_start
busy  out  1  fill engine active
fill_done  out  1  one-cycle pulse when the fill completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Address computation: addr = y*WIDTH + x, computed at full width ceil(log2(WIDTH*HEIGHT)); no truncation or aliasing.
- Out-of-range coordinates (x >= WIDTH or y >= HEIGHT):
  - A read still gets rd_valid next cycle, with rd_data = 0.
  - A write is dropped and memory is unchanged.
- Read latency is exactly 1 cycle. A request at edge N gives rd_valid = 1 and data from edge N+1 until edge N+2. rd_valid is 0 in cycles with no request.
- Port 2 read and write to the same address in one cycle: the write is performed, rd_data2 returns the old content (read-first), and rd_valid2 = 1.
- Port 1 read and port 2 write to the same address in one cycle: rd_data1 returns the old content (read-first).
- Fill FSM states are IDLE and FILL.
  - IDLE -> FILL on fill_start while IDLE and not in reset. On that edge: latch fill_color, set the counter to 0, set busy = 1.
  - In FILL, write the colour to address cnt each cycle and increment cnt.
  - At cnt = WIDTH*HEIGHT-1: write, go to IDLE, set busy = 0, pulse fill_done for exactly 1 cycle.
  - A full fill takes WIDTH*HEIGHT cycles from the accepting edge to the last write; fill_done is high in the cycle after the last write.
- fill_start while busy is ignored, with no restart and no colour change.
- While busy:
  - re2 and we2 are ignored: no write, rd_valid2 stays 0.
  - Port 1 operates normally and may see partially filled data.
- Reset values: rd_data1 = 0, rd_valid1 = 0, rd_data2 = 0, rd_valid2 = 0, busy = 0, fill_done = 0, FSM = IDLE, counter = 0.
- Reset during FILL aborts the fill on that edge. Pixels already written keep the fill colour, the rest keep prior content, and fill_done does not pulse.
- rst and fill_start in the same cycle: reset wins and the fill is not started.
- Reset never alters memory contents; INIT_VALUE applies only at configuration.
- Inputs are sampled on rising edges only; outputs are registered.

Test Plan:
- Power-up read (BPP=4, INIT_VALUE=4'hF): re1 at (0,0), then at (319,199) -> rd_valid1 one cycle later each, rd_data1 = 4'hF both times.
- Write/read: we2 (10,5) data 4'hA, next cycle re1 and re2 at (10,5) -> both rd_data = 4'hA. Same-cycle we2 4'h3 and re2 at (10,5) -> rd_data2 = 4'hA, then a re-read gives 4'h3.
- Bounds: we2 at (320,0) data 4'h5, then re2 at (320,0) and at (0,0) -> rd_data2 = 0 with rd_valid2 = 1; (0,0) unchanged at 4'hF. Pixel (0,1) (addr 320) also unchanged.
- Fill (WIDTH=8, HEIGHT=4): fill_start with fill_color = 4'h2.
  - busy high for 32 cycles and fill_done pulses once.
  - re2/we2 during busy produce no rd_valid2 and no write.
  - A second fill_start mid-fill is ignored.
  - Afterwards all 32 pixels read 4'h2.
- Reset mid-fill: assert rst at cycle 10 of the fill -> busy = 0 and no fill_done. Addresses 0..9 read the fill colour, addresses 10..31 keep old data. A new fill_start is accepted immediately.
- Reset values: assert rst with re1 = re2 = 1 -> all outputs 0 the following cycle.
